muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit that sits downstream of the register file.
- Consumes RD1/RD2 operands plus the op and destination index from decode.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU iteratively, one bit per cycle.
- Returns result and rd on a writeback handshake that feeds the register file's WD3/rd/Regwrite inputs.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- SUPPRESS_X0, 1, when 1 a result destined for rd=0 is discarded and no writeback is issued.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an M-op.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  input  XLEN  rs1 value (RD1).
- in_b  input  XLEN  rs2 value (RD2).
- in_rd  input  5  destination register.
- flush  input  1  abort the in-flight op (branch/trap).
- wb_valid  output  1  result available.
- wb_ready  input  1  writeback port accepts the result.
- wb_rd  output  5  destination register, drives the register file's rd.
- wb_data  output  XLEN  result, drives the register file's WD3.
- busy  output  1  state != IDLE; used by hazard logic to stall dependents.

Behaviour:
- Reset is synchronous, active-high, and has priority over everything. On reset: state=IDLE, wb_valid=0, wb_rd=0, wb_data=0, busy=0, in_ready=1. Reset mid-operation discards the op.
- State IDLE:
  - Accept when in_valid and in_ready are both high at a rising edge. Latch op, rd, operand magnitudes and result-sign flags.
  - Signedness: MULH, DIV and REM treat both operands as signed. MULHSU treats a as signed and b as unsigned. MULHU, DIVU and REMU are fully unsigned. MUL takes the low word, so signedness does not matter.
  - Divide by zero (b=0, divide ops): quotient = all ones, remainder = a. Go straight to DONE.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0. Go straight to DONE.
  - Every other op goes to CALC with count=0.
- State CALC, one iteration per edge:
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract on a (remainder, quotient) pair.
  - After XLEN edges, go to FIX.
- State FIX, one edge:
  - Negate the product if the sign flag is set.
  - Quotient sign = sign(a) XOR sign(b). Remainder takes the sign of a.
  - Select the low word for MUL, the high word for MULH*, the quotient for DIV*, the remainder for REM*.
  - Register the result into wb_data/wb_rd and go to DONE.
- State DONE:
  - wb_valid=1. wb_data and wb_rd stay stable until wb_ready is sampled high; that edge returns to IDLE and clears wb_valid.
  - With SUPPRESS_X0=1 and rd=0, DONE is skipped (FIX or the special case returns directly to IDLE) and wb_valid never asserts.
- Latency:
  - Normal op accepted at edge 0: wb_valid is high after edge XLEN+1 (33 cycles for XLEN=32).
  - Special cases: wb_valid is high after edge 0 (1 cycle).
  - With wb_ready held high, the result is consumed at the first DONE edge.
- Throughput: at most one op in flight. in_ready=0 in CALC, FIX and DONE. Back-to-back: a new op can be accepted on the edge after the wb handshake.
- flush:
  - In CALC or FIX: go to IDLE, no writeback.
  - In DONE: keep the result; the op is already committed.
  - In IDLE together with in_valid: flush wins and nothing is accepted.
- Simultaneous rst and flush: rst wins; the outcome is identical.
- Width: accumulators are internal, 2*XLEN+1 bits. Outputs are exactly XLEN bits, and all arithmetic is modulo 2^XLEN.

Decomposition:
- muldiv_pkg holds:
  - funct3 op constants MD_MUL through MD_REMU;
  - the state encoding typedef (IDLE, CALC, FIX, DONE);
  - XLEN default.
- Sub-module muldiv_step: combinational single iteration, shift-add or restore-subtract selected by an is_div input. It is instantiated once, so the FSM module contains only control and registers.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), rd=5 -> wb_valid 33 cycles after accept, wb_data=0xFFFFFFEB, wb_rd=5.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, both with wb_valid 1 cycle after accept. DIV 0x80000000/-1 -> 0x80000000, and REM of the same -> 0.
- Hold wb_ready=0 for 10 cycles in DONE -> wb_valid, wb_data and wb_rd stable, in_ready=0. Raise wb_ready -> IDLE next edge, and a second op is accepted on the following edge.
- flush at CALC cycle 10 -> IDLE, no wb_valid. rst at cycle 20 of a DIV -> all outputs at their reset values the next edge. rd=0 MUL with SUPPRESS_X0=1 -> no wb_valid, and busy drops after FIX.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and op decode for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // upper: high product word for MULH*, remainder for REM*
    typedef struct packed {
        logic is_div;
        logic a_signed;
        logic b_signed;
        logic upper;
    } md_dec_t;

    function automatic md_dec_t md_decode(input logic [2:0] op);
        md_dec_t d;
        d = '0;
        case (op)
            MD_MUL:    d = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b0};
            MD_MULH:   d = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b1};
            MD_MULHSU: d = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, upper: 1'b1};
            MD_MULHU:  d = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b1};
            MD_DIV:    d = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b0};
            MD_DIVU:   d = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b0};
            MD_REM:    d = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, upper: 1'b1};
            default:   d = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, upper: 1'b1};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue and writeback handshake bundle between decode, the M unit and the register file.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;
    logic            flush;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, flush, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, flush, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register acc_next.
module muldiv_step import muldiv_pkg::*; #(
    parameter int XLEN = MD_XLEN
) (
    input  logic              is_div,
    input  logic [2*XLEN:0]   acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN:0]   acc_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;

    // acc layout: multiply {carry+hi, lo/multiplier}; divide {remainder, quotient/dividend}
    always_comb begin
        sum    = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_next = {rem_sh - {1'b0, opnd}, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh, acc[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {1'b0, sum, acc[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle, one op in flight.
// Latency: XLEN+1 cycles accept-to-wb_valid; divide-by-zero and signed overflow 1 cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until wb_ready.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int XLEN        = MD_XLEN,
    parameter bit SUPPRESS_X0 = 1'b1
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int              ACC_W = 2*XLEN + 1;
    localparam int              CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    md_dec_t           in_dec;
    logic              is_div_q, upper_q, neg_q, neg_r_q;
    logic [4:0]        rd_q;
    logic [ACC_W-1:0]  acc_q, acc_step;
    logic [XLEN-1:0]   opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        wb_rd_q;

    logic              accept, a_neg, b_neg, div_zero, div_ovf, special;
    logic              drop_in, drop_q;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_step)
    );

    // Issue-side decode: magnitudes, sign flags and the two early-out cases
    always_comb begin
        in_dec   = md_decode(bus.in_op);
        accept   = bus.in_valid && (state_q == IDLE) && !bus.flush;
        a_neg    = in_dec.a_signed & bus.in_a[XLEN-1];
        b_neg    = in_dec.b_signed & bus.in_b[XLEN-1];
        mag_a    = a_neg ? -bus.in_a : bus.in_a;
        mag_b    = b_neg ? -bus.in_b : bus.in_b;
        div_zero = in_dec.is_div && (bus.in_b == '0);
        div_ovf  = in_dec.is_div && in_dec.a_signed && (bus.in_a == SMIN) && (bus.in_b == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = in_dec.upper ? bus.in_a : '1;
        end else begin
            special_res = in_dec.upper ? '0 : SMIN;
        end
        drop_in  = SUPPRESS_X0 && (bus.in_rd == 5'd0);
        drop_q   = SUPPRESS_X0 && (rd_q == 5'd0);
    end

    // Sign fix-up and result selection, registered in FIX
    always_comb begin
        prod = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = XLEN'(neg_r_q ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN]);
        if (is_div_q) begin
            fix_res = upper_q ? rem : quo;
        end else begin
            fix_res = upper_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_d = drop_in ? IDLE : DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (bus.flush || drop_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
        bus.busy     = (state_q != IDLE);
        bus.wb_valid = (state_q == DONE);
        bus.wb_data  = wb_data_q;
        bus.wb_rd    = wb_rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div_q  <= 1'b0;
            upper_q   <= 1'b0;
            neg_q     <= 1'b0;
            neg_r_q   <= 1'b0;
            rd_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_rd_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_div_q <= in_dec.is_div;
                        upper_q  <= in_dec.upper;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        rd_q     <= bus.in_rd;
                        acc_q    <= {{(XLEN+1){1'b0}}, mag_a};
                        opnd_q   <= mag_b;
                        cnt_q    <= '0;
                        if (special && !drop_in) begin
                            wb_data_q <= special_res;
                            wb_rd_q   <= bus.in_rd;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    if (!bus.flush && !drop_q) begin
                        wb_data_q <= fix_res;
                        wb_rd_q   <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .SUPPRESS_X0(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: return (b == 32'd0) ? a : 32'(sa % sb);
            default: return (b == 32'd0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 32'd0) return 0;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        bus.in_valid = 1'b1;
        check("in_ready before accept", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (bus.wb_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        bus.wb_ready = 1'b1;
        start_op(op, a, b, rd);
        wait_wb(n);
        check($sformatf("%s latency", tag), 32'(n), 32'(ref_lat(op, a, b)));
        check($sformatf("%s data", tag), bus.wb_data, ref_md(op, a, b));
        check($sformatf("%s rd", tag), 32'(bus.wb_rd), 32'(rd));
        tick();
        check($sformatf("%s consumed", tag), 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        int          n;
        logic        saw;
        logic [2:0]  rop;
        logic [31:0] ra, rb, held_d;
        logic [4:0]  rrd;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_rd = '0;
        bus.flush = 1'b0; bus.wb_ready = 1'b1;
        repeat (3) tick();
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("reset wb_data", bus.wb_data, 32'd0);
        check("reset wb_rd", 32'(bus.wb_rd), 32'd0);
        rst = 1'b0;
        tick();

        run_op("MUL 7*-3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op("MULH min*min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd6);
        run_op("MULHU max*max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        run_op("MULHSU -1*max", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
        run_op("DIV -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op("REM -7%2", MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
        run_op("DIVU 100/7", MD_DIVU, 32'd100, 32'd7, 5'd11);
        run_op("REMU 100%7", MD_REMU, 32'd100, 32'd7, 5'd12);
        run_op("DIVU 5/0", MD_DIVU, 32'd5, 32'd0, 5'd13);
        run_op("REM 5%0", MD_REM, 32'd5, 32'd0, 5'd14);
        run_op("DIV ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run_op("REM ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

        // Stall in DONE, then back-to-back issue
        bus.wb_ready = 1'b0;
        start_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17);
        wait_wb(n);
        check("stall latency", 32'(n), 32'd33);
        held_d = ref_md(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("stall %0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
            check($sformatf("stall %0d wb_data", i), bus.wb_data, held_d);
            check($sformatf("stall %0d wb_rd", i), 32'(bus.wb_rd), 32'd17);
            check($sformatf("stall %0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.wb_ready = 1'b1;
        tick();
        check("release wb_valid", 32'(bus.wb_valid), 32'd0);
        check("release in_ready", 32'(bus.in_ready), 32'd1);
        run_op("back-to-back MUL", MD_MUL, 32'hDEAD_BEEF, 32'd3, 5'd18);

        // Flush in CALC
        start_op(MD_DIVU, 32'hFFFF_0000, 32'd3, 5'd19);
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush calc busy", 32'(bus.busy), 32'd0);
        check("flush calc in_ready", 32'(bus.in_ready), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw = saw | bus.wb_valid;
        end
        check("flush calc no wb", 32'(saw), 32'd0);

        // Flush with in_valid in IDLE: nothing accepted
        bus.in_op = MD_MUL; bus.in_a = 32'd2; bus.in_b = 32'd3; bus.in_rd = 5'd4;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        check("flush idle busy", 32'(bus.busy), 32'd0);

        // Flush in DONE keeps the committed result
        bus.wb_ready = 1'b0;
        start_op(MD_DIVU, 32'd100, 32'd7, 5'd3);
        wait_wb(n);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush done wb_valid", 32'(bus.wb_valid), 32'd1);
        check("flush done wb_data", bus.wb_data, 32'd14);
        bus.wb_ready = 1'b1;
        tick();
        check("flush done consumed", 32'(bus.wb_valid), 32'd0);

        // Reset (with flush) partway through a DIV
        start_op(MD_DIV, 32'hFFFF_FF9C, 32'd7, 5'd12);
        repeat (20) tick();
        rst = 1'b1;
        bus.flush = 1'b1;
        tick();
        rst = 1'b0;
        bus.flush = 1'b0;
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid rst busy", 32'(bus.busy), 32'd0);
        check("mid rst wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mid rst wb_data", bus.wb_data, 32'd0);
        check("mid rst wb_rd", 32'(bus.wb_rd), 32'd0);

        // rd=0 result is discarded; busy drops after FIX
        start_op(MD_MUL, 32'd3, 32'd4, 5'd0);
        saw = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            saw = saw | bus.wb_valid;
            if (k == 32) check("x0 busy in FIX", 32'(bus.busy), 32'd1);
            if (k == 33) check("x0 busy after FIX", 32'(bus.busy), 32'd0);
        end
        check("x0 no wb", 32'(saw), 32'd0);
        check("x0 wb_data untouched", bus.wb_data, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rrd = 5'($urandom_range(1, 31));
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rrd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
